// File: rtl/cmd_link.sv
// cmd_link: MazeRunner end of the bluetooth command link.
// Receives two-byte commands over 8N1 UART and sends back a one-byte response.
module cmd_link #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam logic [11:0] FULL_RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_RELOAD = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {ASM_WAIT_HI, ASM_WAIT_LO} asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [11:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_rdy_q, rx_rdy_d;
    logic        rx_err_q, rx_err_d;

    asm_state_t  asm_state_q, asm_state_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    tx_state_t   tx_state_q, tx_state_d;
    logic [11:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic        resp_sent_q, resp_sent_d;

    // RX is asynchronous; rx_prev_q gives the falling-edge detect after the two sync stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_rdy_d   = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_RELOAD;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 12'd0) begin
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = FULL_RELOAD;
                        rx_bit_d   = 4'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                        rx_cnt_d   = 12'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 12'd0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = FULL_RELOAD;
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 12'd0) begin
                    rx_rdy_d   = rx_sync_q;
                    rx_err_d   = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = 12'd0;
                end else begin
                    rx_cnt_d = rx_cnt_q - 12'd1;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = 12'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 12'd0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 8'd0;
            rx_rdy_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // High byte waits in hi_byte_q so cmd only ever changes as a complete pair.
    always_comb begin
        asm_state_d = asm_state_q;
        hi_byte_d   = hi_byte_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        case (asm_state_q)
            ASM_WAIT_HI: begin
                if (rx_rdy_q) begin
                    hi_byte_d   = rx_shift_q;
                    cmd_rdy_d   = 1'b0;
                    asm_state_d = ASM_WAIT_LO;
                end
            end
            ASM_WAIT_LO: begin
                if (rx_rdy_q) begin
                    cmd_d       = {hi_byte_q, rx_shift_q};
                    cmd_rdy_d   = 1'b1;
                    asm_state_d = ASM_WAIT_HI;
                end else if (rx_err_q) begin
                    hi_byte_d   = 8'd0;
                    asm_state_d = ASM_WAIT_HI;
                end
            end
            default: asm_state_d = ASM_WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state_q <= ASM_WAIT_HI;
            hi_byte_q   <= 8'd0;
            cmd_q       <= 16'd0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            asm_state_q <= asm_state_d;
            hi_byte_q   <= hi_byte_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
        end
    end

    // TX is bit 0 of the frame shifter; ones shift in so the line idles high.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_shift_d  = {1'b1, resp, 1'b0};
                    tx_cnt_d    = FULL_RELOAD;
                    tx_bit_d    = 4'd0;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt_q == 12'd0) begin
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_cnt_d   = FULL_RELOAD;
                    if (tx_bit_q == 4'd9) begin
                        tx_cnt_d    = 12'd0;
                        resp_sent_d = 1'b1;
                        tx_state_d  = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 12'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= 12'd0;
            tx_bit_q    <= 4'd0;
            tx_shift_q  <= '1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = tx_shift_q[0];
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_link.sv
// Bench for cmd_link: byte-vector table, hand-built corner sequences and a
// randomized byte stream checked against a command-pair reference model.
module tb_cmd_link;

    localparam int B = 32;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
    logic [15:0] cmd;
    logic [7:0]  resp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  b;
        logic        stop_ok;
        logic        clr_after;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs[9];

    cmd_link #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame plus two idle bit times; reports the frame offset where cmd_rdy rose.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic release_clr,
                             output int rise_k);
        logic [9:0] frame;
        logic       prev_rdy;
        frame    = {stop_ok, b, 1'b0};
        rise_k   = -1;
        prev_rdy = cmd_rdy;
        for (int k = 0; k < 12 * B; k++) begin
            RX = (k < 10 * B) ? frame[k / B] : 1'b1;
            if (!prev_rdy && cmd_rdy && rise_k < 0) rise_k = k;
            prev_rdy = cmd_rdy;
            if (release_clr && clr_cmd_rdy && cmd_rdy) clr_cmd_rdy = 1'b0;
            @(negedge clk);
        end
    endtask

    // Requests a response and decodes the line at each bit centre.
    task automatic tx_frame(input logic [7:0] r, input logic poke, output logic [7:0] got,
                            output int len, output logic start_ok, output logic stop_ok,
                            output logic extra_low);
        int idx;
        resp      = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        resp      = ~r;
        got       = 8'h00;
        len       = -1;
        start_ok  = 1'b0;
        stop_ok   = 1'b0;
        extra_low = 1'b0;
        for (int k = 0; k < 12 * B; k++) begin
            if (k < 10 * B && (k % B) == B / 2) begin
                idx = k / B;
                if (idx == 0) start_ok = (TX == 1'b0);
                else if (idx == 9) stop_ok = TX;
                else got[idx-1] = TX;
            end
            if (poke && k == 4 * B + 3) begin
                send_resp = 1'b1;
                resp      = 8'h3C;
            end else if (poke && k == 4 * B + 4) begin
                send_resp = 1'b0;
            end
            if (len < 0 && resp_sent) len = k;
            if (k >= 10 * B && TX == 1'b0) extra_low = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0]  got, rb, hi;
        logic        s_ok, p_ok, extra, ok, have_hi, exp_rdy;
        logic [15:0] exp_cmd;
        int          len, rk;

        vecs = '{
            '{8'h60, 1'b1, 1'b0, 16'h0000, 1'b0},
            '{8'h00, 1'b1, 1'b1, 16'h6000, 1'b1},
            '{8'h12, 1'b0, 1'b0, 16'h6000, 1'b0},
            '{8'h34, 1'b1, 1'b0, 16'h6000, 1'b0},
            '{8'h56, 1'b1, 1'b0, 16'h3456, 1'b1},
            '{8'hAB, 1'b1, 1'b0, 16'h3456, 1'b0},
            '{8'h77, 1'b0, 1'b0, 16'h3456, 1'b0},
            '{8'hCD, 1'b1, 1'b0, 16'h3456, 1'b0},
            '{8'hEF, 1'b1, 1'b0, 16'hCDEF, 1'b1}
        };

        rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(TX), 32'd1);
        chk("reset_cmd", 32'(cmd), 32'h0);
        chk("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("reset_resp_sent", 32'(resp_sent), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        tx_frame(8'hA5, 1'b1, got, len, s_ok, p_ok, extra);
        chk("tx_a5_data", 32'(got), 32'hA5);
        chk("tx_a5_start", 32'(s_ok), 32'd1);
        chk("tx_a5_stop", 32'(p_ok), 32'd1);
        chk("tx_a5_len", 32'(len), 32'(10 * B));
        chk("tx_a5_no_second_frame", 32'(extra), 32'd0);
        chk("tx_a5_resp_sent_held", 32'(resp_sent), 32'd1);

        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].b, vecs[i].stop_ok, 1'b0, rk);
            chk($sformatf("vec%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            chk($sformatf("vec%0d_rdy", i), 32'(cmd_rdy), 32'(vecs[i].exp_rdy));
            if (vecs[i].clr_after) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                chk($sformatf("vec%0d_clr", i), 32'(cmd_rdy), 32'd0);
            end
        end

        // Abort a receive and a transmit with reset.
        resp = 8'h00; send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        RX = 1'b0;
        repeat (3 * B + 5) @(negedge clk);
        chk("midframe_tx_low", 32'(TX), 32'd0);
        chk("midframe_rdy_before_rst", 32'(cmd_rdy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(TX), 32'd1);
        chk("abort_cmd", 32'(cmd), 32'h0);
        chk("abort_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("abort_resp_sent", 32'(resp_sent), 32'd0);
        RX = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2 * B) @(negedge clk);

        send_byte(8'h60, 1'b1, 1'b0, rk);
        send_byte(8'h00, 1'b1, 1'b0, rk);
        chk("pair6000_cmd", 32'(cmd), 32'h6000);
        chk("pair6000_rdy", 32'(cmd_rdy), 32'd1);
        chk("pair6000_latency_window",
            32'(rk > 9 * B + B / 2 && rk <= 9 * B + B / 2 + 6), 32'd1);

        RX = 1'b0;
        repeat (B / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch_cmd", 32'(cmd), 32'h6000);
        chk("glitch_rdy", 32'(cmd_rdy), 32'd1);

        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("clr_drop", 32'(cmd_rdy), 32'd0);
        chk("clr_cmd_stable", 32'(cmd), 32'h6000);

        send_byte(8'hAB, 1'b1, 1'b0, rk);
        send_byte(8'hCD, 1'b1, 1'b0, rk);
        chk("pairABCD_cmd", 32'(cmd), 32'hABCD);
        chk("pairABCD_rdy", 32'(cmd_rdy), 32'd1);

        // Receive 0x0000 while transmitting; clr held until the completing cycle.
        fork
            tx_frame(8'hA5, 1'b0, got, len, s_ok, p_ok, extra);
            begin
                send_byte(8'h00, 1'b1, 1'b0, rk);
                chk("sim_hi_clears_rdy", 32'(cmd_rdy), 32'd0);
                clr_cmd_rdy = 1'b1;
                send_byte(8'h00, 1'b1, 1'b1, rk);
            end
        join
        chk("sim_set_beats_clr", 32'(clr_cmd_rdy), 32'd0);
        clr_cmd_rdy = 1'b0;
        chk("sim_cmd", 32'(cmd), 32'h0000);
        chk("sim_rdy", 32'(cmd_rdy), 32'd1);
        chk("sim_tx_data", 32'(got), 32'hA5);
        chk("sim_tx_framing", 32'({s_ok, p_ok, extra}), 32'b110);
        chk("sim_tx_len", 32'(len), 32'(10 * B));

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        have_hi = 1'b0; hi = 8'h00; exp_cmd = 16'h0000; exp_rdy = 1'b0;
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_byte(rb, ok, 1'b0, rk);
            if (!ok) begin
                have_hi = 1'b0;
            end else if (!have_hi) begin
                hi = rb; have_hi = 1'b1; exp_rdy = 1'b0;
            end else begin
                exp_cmd = {hi, rb}; exp_rdy = 1'b1; have_hi = 1'b0;
            end
            chk($sformatf("rand%0d_cmd", n), 32'(cmd), 32'(exp_cmd));
            chk($sformatf("rand%0d_rdy", n), 32'(cmd_rdy), 32'(exp_rdy));
            if ($urandom_range(0, 2) == 0) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                exp_rdy = 1'b0;
                chk($sformatf("rand%0d_clr", n), 32'(cmd_rdy), 32'(exp_rdy));
            end
        end
        for (int n = 0; n < 3; n++) begin
            rb = 8'($urandom);
            tx_frame(rb, 1'b0, got, len, s_ok, p_ok, extra);
            chk($sformatf("rand_tx%0d_data", n), 32'(got), 32'(rb));
            chk($sformatf("rand_tx%0d_len", n), 32'(len), 32'(10 * B));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_link.md
Name: cmd_link

Overview:
- MazeRunner-side endpoint of the bluetooth command link. It is the far end of the remote command module: it receives a 16-bit command over UART as two bytes (high byte first) and presents it to the command processor with a ready flag.
- It transmits one 8-bit response byte (0xA5 = positive ack) back over UART on request.
- It contains its own UART receiver and transmitter, both 8N1, LSB first, idle high.

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); legal range 16..4095.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- RX  input  1  serial in from the remote module (asynchronous, idle high)
- TX  output  1  serial out to the remote module
- cmd  output  16  assembled command {high_byte, low_byte}
- cmd_rdy  output  1  complete command available
- clr_cmd_rdy  input  1  consumer acknowledges cmd; clears cmd_rdy
- resp  input  8  response byte to transmit
- send_resp  input  1  one-cycle pulse; start transmitting resp
- resp_sent  output  1  response transmission complete

Behaviour:
- Reset values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0. Both FSMs go to IDLE and all counters clear.
- Reset is asynchronous. Asserting rst mid-frame aborts the frame: TX returns high immediately and any partial byte is discarded.

RX path:
- RX is double-flop synchronized before any use; it is reset to 1.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
- START: wait BAUD_DIV/2 clocks, then sample. If the sample is 0 -> DATA; if 1 (glitch) -> IDLE.
- DATA: sample every BAUD_DIV clocks, 8 bits, LSB first into the shift register.
- STOP: sample after BAUD_DIV clocks.
  - Sample = 1: byte valid; pulse rx_rdy internally for 1 clock.
  - Sample = 0: framing error; byte dropped, no rx_rdy.
  - Either way -> IDLE.

Byte assembly:
- States: WAIT_HI, WAIT_LO.
- WAIT_HI + rx_rdy: latch byte into cmd[15:8] -> WAIT_LO.
- WAIT_LO + rx_rdy: latch byte into cmd[7:0], set cmd_rdy on the next edge -> WAIT_HI.
- A framing error in WAIT_LO discards the stored high byte and returns to WAIT_HI.
- cmd is stable while cmd_rdy=1 and is only updated by a new completed pair.

cmd_rdy:
- Cleared by clr_cmd_rdy.
- Also cleared when a new high byte is latched. A new command in progress invalidates the old one.
- If clr_cmd_rdy and low-byte completion happen in the same cycle, set wins and cmd_rdy=1.
- Latency: cmd_rdy rises 1 clock after the mid-point sample of the low byte's stop bit.

TX path:
- TX FSM states: IDLE, XMIT.
- send_resp in IDLE loads the frame {1, resp, 0} into a 10-bit shift register.
- On the same edge, resp_sent clears and the FSM goes to XMIT.
- TX shows the start bit from the next clock.
- Each bit is held exactly BAUD_DIV clocks; the frame is 10*BAUD_DIV clocks total.
- After the stop bit completes: resp_sent=1 -> IDLE. resp_sent stays high until the next send_resp.
- send_resp while in XMIT is ignored; the current frame is not corrupted.
- resp is sampled only at the accepting edge.
- TX and RX operate fully independently; simultaneous receive and transmit is required to work.

Counters:
- Baud counter: 12 bits, reloads on each state transition, never wraps mid-bit.
- Bit counter: 4 bits.

Test Plan:
- Reset sequence with a cmd in flight:
  - Stimulus: assert rst mid-frame.
  - Response: TX=1, cmd=0, cmd_rdy=0, resp_sent=0; a subsequent clean 0x6000 still decodes correctly.
- Normal command pair:
  - Stimulus: remote sends bytes 0x60 then 0x00 at BAUD_DIV=2604.
  - Response: cmd=16'h6000 and cmd_rdy=1 within 1 clock after the low-byte stop mid-point; cmd_rdy drops the cycle after a clr_cmd_rdy pulse.
- Response transmit:
  - Stimulus: send_resp with resp=8'hA5.
  - Response: remote receives 0xA5; TX frame length is exactly 26040 clocks; resp_sent rises at the end.
  - Stimulus: a second send_resp pulsed mid-frame.
  - Response: ignored; still a single 0xA5 frame.
- Framing error:
  - Stimulus: high byte 0x12 with stop bit forced 0, then a valid pair 0x34, 0x56.
  - Response: no cmd_rdy on the bad byte; final cmd=16'h3456.
- Glitch rejection:
  - Stimulus: RX low pulse of BAUD_DIV/4 clocks.
  - Response: no byte accepted; FSM back in IDLE; a following pair 0xAB, 0xCD yields cmd=16'hABCD.
- Simultaneous traffic:
  - Stimulus: 0x0000 received while 0xA5 is being transmitted, with clr_cmd_rdy coincident with a later completion.
  - Response: cmd=16'h0000 with cmd_rdy=1; TX frame intact; set-priority holds cmd_rdy high.
